hazard_pattern_decoder: RTL and testbench
=========================================

# hazard_pattern_decoder

Observer on the three-lamp hazard-light bus. It samples the lamp pattern on each qualified tick and classifies the transition between consecutive samples. From that it reconstructs the two-bit switch code that produced the pattern, reports lock once the code is stable, and flags patterns that no legal switch setting can produce. It sits beside the hazard-light controller on the same clock and taps the controller's lamp outputs for self-check and display.

## Interface
- LOCK_COUNT, default 3: consecutive agreeing transitions required to lock; legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- tick  in  1  sample qualifier; state advances only on edges where tick=1.
- lights  in  3  lamp pattern under observation, bit 2 = left lamp.
- sw_est  out  2  reconstructed switch code: 00 calm, 01 pattern A, 10 pattern B.
- locked  out  1  high while sw_est is backed by LOCK_COUNT agreeing transitions.
- err  out  1  illegal pattern or transition detected.
- mode_chg  out  1  one-cycle pulse when sw_est changes value while locked.

## Operation
- Legal patterns are 101, 010, 001 and 100. Any other value (000, 011, 110, 111) is a BAD sample.
- Registers:
  - prev[2:0], the last legal sample.
  - prev_valid.
  - cand[1:0], the candidate code.
  - cnt, saturating at LOCK_COUNT.
  - sw_est, locked, err, mode_chg.
- First tick after reset, or after prev_valid=0: a legal sample loads prev and sets prev_valid. No classification is made. An illegal sample raises err and prev_valid stays 0.
- Classification of (prev, lights) on a tick:
  - CALM (00): 010→101, 001→101, 100→101.
  - A (01): 010→100, 100→001, 001→010.
  - B (10): 010→001, 001→100, 100→010.
  - AMBIG: 101→010. Every mode passes through this transition.
  - BAD: any repeated pattern, any other pair, or an illegal lights value.
- Class CALM, A or B:
  - If class == cand, cnt increments, saturating at LOCK_COUNT.
  - Otherwise cand ← class and cnt ← 1.
- Lock: when the updated cnt equals LOCK_COUNT, set locked=1 and sw_est←cand.
  - If locked was already 1 and sw_est changes value, pulse mode_chg.
  - A disagreeing transition while locked does not drop lock. sw_est holds its old value until the new candidate reaches LOCK_COUNT.
- AMBIG: cand, cnt, sw_est and locked are unchanged; prev updates.
- BAD:
  - err asserts.
  - cnt←0, cand←00, locked←0; sw_est holds its last value.
  - prev←lights and prev_valid←1 if lights is legal; otherwise prev_valid←0.
- tick=0: all registers hold. mode_chg and the non-sticky err clear.
- Reset values: sw_est=00, locked=0, err=0, mode_chg=0, cnt=0, cand=00, prev=000, prev_valid=0.

## Timing
- All outputs are registered. The effect of a tick edge is visible on the outputs in the following cycle. Latency is one clock from the sampled edge.
- Minimum lock latency from reset: LOCK_COUNT+1 ticks (one tick loads prev, then LOCK_COUNT classified ticks).
- Continuous tick=1 is supported; tick may have any duty cycle.
- mode_chg is exactly one clock wide.
- A BAD sample on the same tick that would complete a lock: BAD wins, so locked=0 and mode_chg=0.
- Reset asserted mid-stream clears everything asynchronously, without waiting for clk. The first tick after release only reloads prev.
- cnt saturates at LOCK_COUNT and never wraps.

## Configuration
- HAZARD_DEC_STICKY_ERR_EN
  - Defined: err is sticky. Once set, it stays high until reset, regardless of later legal traffic.
  - Undefined: err is a one-cycle pulse for each BAD tick and clears on the next edge unless another BAD tick occurs.
- Classification, locking and sw_est behave identically in both builds.

## Test plan
- Reset, then tick every cycle with lights 010,100,001,010 (LOCK_COUNT=3) → locked=1, sw_est=01 one cycle after the 4th tick; err=0, mode_chg=0.
- Locked on 01, then feed 010,001,100,010 → sw_est stays 01 for two ticks, then becomes 10 with a single-cycle mode_chg and locked=1 throughout.
- Calm stream 101,010,101,010,101,010,101 → AMBIG ticks are ignored; locked=1, sw_est=00 after the third 010→101 transition.
- While locked on 10, inject lights=111 → locked=0 and err=1 next cycle; sw_est stays 10. Macro undefined: err clears after one cycle. Macro defined: err stays 1 until reset.
- Repeated pattern 100,100 and illegal jump 101→001 → each gives err and cnt=0. Recovery needs LOCK_COUNT fresh agreeing transitions.
- Assert reset mid-lock between clock edges → all outputs are 0/00 immediately. Toggling tick=0 for several cycles afterwards leaves all outputs unchanged.

Source files
------------

// File: rtl/hazard_pattern_decoder.sv
// Observer that reconstructs the hazard switch code from the three-lamp bus.
// Optional build macro HAZARD_DEC_STICKY_ERR_EN makes err sticky until reset.
module hazard_pattern_decoder #(
  parameter int LOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] lights,
  output logic [1:0] sw_est,
  output logic       locked,
  output logic       err,
  output logic       mode_chg
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  localparam logic [2:0] CLS_CALM  = 3'd0;
  localparam logic [2:0] CLS_A     = 3'd1;
  localparam logic [2:0] CLS_B     = 3'd2;
  localparam logic [2:0] CLS_AMBIG = 3'd3;
  localparam logic [2:0] CLS_BAD   = 3'd4;

`ifdef HAZARD_DEC_STICKY_ERR_EN
  localparam bit STICKY_ERR = 1'b1;
`else
  localparam bit STICKY_ERR = 1'b0;
`endif

  function automatic logic is_legal(input logic [2:0] p);
    return (p == 3'b101) || (p == 3'b010) || (p == 3'b001) || (p == 3'b100);
  endfunction

  // Maps a (previous, current) lamp pair to the switch setting that produces it.
  function automatic logic [2:0] classify(input logic [2:0] p, input logic [2:0] c);
    logic [2:0] r;
    r = CLS_BAD;
    if (is_legal(c)) begin
      case ({p, c})
        6'b010_101, 6'b001_101, 6'b100_101: r = CLS_CALM;
        6'b010_100, 6'b100_001, 6'b001_010: r = CLS_A;
        6'b010_001, 6'b001_100, 6'b100_010: r = CLS_B;
        6'b101_010:                         r = CLS_AMBIG;
        default:                            r = CLS_BAD;
      endcase
    end
    return r;
  endfunction

  logic [2:0] prev, prev_nxt;
  logic       prev_valid, prev_valid_nxt;
  logic [1:0] cand, cand_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_new;
  logic [1:0] sw_est_nxt;
  logic       locked_nxt, err_nxt, mode_chg_nxt;
  logic [2:0] cls;

  always_comb begin
    prev_nxt       = prev;
    prev_valid_nxt = prev_valid;
    cand_nxt       = cand;
    cnt_nxt        = cnt;
    sw_est_nxt     = sw_est;
    locked_nxt     = locked;
    err_nxt        = STICKY_ERR ? err : 1'b0;
    mode_chg_nxt   = 1'b0;
    cnt_new        = 4'd1;
    cls            = classify(prev, lights);

    if (tick) begin
      if (!prev_valid) begin
        // No reference sample yet: only seed prev, never classify.
        if (is_legal(lights)) begin
          prev_nxt       = lights;
          prev_valid_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end else if (cls == CLS_BAD) begin
        err_nxt    = 1'b1;
        cnt_nxt    = 4'd0;
        cand_nxt   = 2'b00;
        locked_nxt = 1'b0;
        if (is_legal(lights)) begin
          prev_nxt       = lights;
          prev_valid_nxt = 1'b1;
        end else begin
          prev_valid_nxt = 1'b0;
        end
      end else if (cls == CLS_AMBIG) begin
        prev_nxt = lights;
      end else begin
        prev_nxt = lights;
        if (cls[1:0] == cand)
          cnt_new = (cnt >= LC) ? LC : cnt + 4'd1;
        cand_nxt = cls[1:0];
        cnt_nxt  = cnt_new;
        if (cnt_new == LC) begin
          locked_nxt   = 1'b1;
          sw_est_nxt   = cls[1:0];
          mode_chg_nxt = locked && (sw_est != cls[1:0]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= 3'b000;
      prev_valid <= 1'b0;
      cand       <= 2'b00;
      cnt        <= 4'd0;
      sw_est     <= 2'b00;
      locked     <= 1'b0;
      err        <= 1'b0;
      mode_chg   <= 1'b0;
    end else begin
      prev       <= prev_nxt;
      prev_valid <= prev_valid_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      sw_est     <= sw_est_nxt;
      locked     <= locked_nxt;
      err        <= err_nxt;
      mode_chg   <= mode_chg_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_pattern_decoder.sv
// Directed bench for hazard_pattern_decoder (LOCK_COUNT=3), both err builds.
module tb_hazard_pattern_decoder;

`ifdef HAZARD_DEC_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] lights = 3'b000;
  logic [1:0] sw_est;
  logic       locked, err, mode_chg;

  int checks = 0;
  int failures = 0;
  bit err_seen = 1'b0;

  hazard_pattern_decoder #(.LOCK_COUNT(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .lights(lights),
    .sw_est(sw_est), .locked(locked), .err(err), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then check the registered outputs after the edge.
  task automatic step(input string tag, input logic t, input logic [2:0] l,
                      input logic [1:0] e_sw, input logic e_lock,
                      input logic e_bad, input logic e_mc);
    logic e_err;
    @(negedge clk);
    tick = t;
    lights = l;
    @(posedge clk);
    #1;
    if (e_bad) err_seen = 1'b1;
    e_err = e_bad | (STICKY & err_seen);
    check({tag, ".sw"},   {2'b00, sw_est},   {2'b00, e_sw});
    check({tag, ".lock"}, {3'b000, locked},  {3'b000, e_lock});
    check({tag, ".err"},  {3'b000, err},     {3'b000, e_err});
    check({tag, ".mc"},   {3'b000, mode_chg}, {3'b000, e_mc});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sw"},   {2'b00, sw_est},    4'h0);
    check({tag, ".lock"}, {3'b000, locked},   4'h0);
    check({tag, ".err"},  {3'b000, err},      4'h0);
    check({tag, ".mc"},   {3'b000, mode_chg}, 4'h0);
  endtask

  initial begin
    #12;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // Pattern A lock: load, then three agreeing transitions.
    step("a_load", 1, 3'b010, 2'b00, 0, 0, 0);
    step("a_1",    1, 3'b100, 2'b00, 0, 0, 0);
    step("a_2",    1, 3'b001, 2'b00, 0, 0, 0);
    step("a_3",    1, 3'b010, 2'b01, 1, 0, 0);
    step("a_idle", 0, 3'b111, 2'b01, 1, 0, 0);

    // Switch to pattern B while locked.
    step("b_1",    1, 3'b001, 2'b01, 1, 0, 0);
    step("b_2",    1, 3'b100, 2'b01, 1, 0, 0);
    step("b_3",    1, 3'b010, 2'b10, 1, 0, 1);
    step("b_idle", 0, 3'b010, 2'b10, 1, 0, 0);

    // Illegal lamp value while locked on B.
    step("bad111", 1, 3'b111, 2'b10, 0, 1, 0);
    step("bad_nx", 0, 3'b111, 2'b10, 0, 0, 0);

    // Calm stream: AMBIG 101->010 transitions are ignored.
    step("c_load", 1, 3'b101, 2'b10, 0, 0, 0);
    step("c_amb1", 1, 3'b010, 2'b10, 0, 0, 0);
    step("c_1",    1, 3'b101, 2'b10, 0, 0, 0);
    step("c_amb2", 1, 3'b010, 2'b10, 0, 0, 0);
    step("c_2",    1, 3'b101, 2'b10, 0, 0, 0);
    step("c_amb3", 1, 3'b010, 2'b10, 0, 0, 0);
    step("c_3",    1, 3'b101, 2'b00, 1, 0, 0);

    // Illegal jump and repeated pattern, then recovery with a BAD on the way.
    step("jump",   1, 3'b001, 2'b00, 0, 1, 0);
    step("repeat", 1, 3'b001, 2'b00, 0, 1, 0);
    step("r_1",    1, 3'b010, 2'b00, 0, 0, 0);
    step("r_2",    1, 3'b100, 2'b00, 0, 0, 0);
    step("rep2",   1, 3'b100, 2'b00, 0, 1, 0);
    step("r2_1",   1, 3'b001, 2'b00, 0, 0, 0);
    step("r2_2",   1, 3'b010, 2'b00, 0, 0, 0);
    step("r2_3",   1, 3'b100, 2'b01, 1, 0, 0);
    // Saturated count keeps lock without further pulses.
    for (int i = 0; i < 6; i++) begin
      step("sat", 1, (i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100,
           2'b01, 1, 0, 0);
    end

    // Asynchronous reset between edges while locked.
    #2;
    reset = 1'b0;
    #1;
    err_seen = 1'b0;
    check_zero("arst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 0, 3'b010, 2'b00, 0, 0, 0);

    // First tick after reset: illegal sample flags err, legal one only loads.
    step("p_bad",  1, 3'b111, 2'b00, 0, 1, 0);
    step("p_load", 1, 3'b010, 2'b00, 0, 0, 0);
    step("p_1",    1, 3'b100, 2'b00, 0, 0, 0);
    step("p_2",    1, 3'b001, 2'b00, 0, 0, 0);
    step("p_3",    1, 3'b010, 2'b01, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
